regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 126 ++++++++++++
 tb/tb_regfile_mp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-ported register file with an issue scoreboard.
//               Two write ports, three combinational read ports with
//               write-through bypass, and one pending bit per register that
//               is set when an instruction issues and cleared on writeback.
//               Register 0 is hardwired to zero and is never busy.
// Ports       :
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   we0/wa0/wd0         write port 0 (enable, address, data)
//   we1/wa1/wd1         write port 1 (higher priority than port 0)
//   ra0/ra1/ra2         read addresses
//   rd0/rd1/rd2         read data (bypassed from same-cycle writes)
//   busy0/busy1/busy2   scoreboard pending bit for each read address
//   iss_v/iss_rd        issue strobe and claimed destination register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   ra0,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd0,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy0,
  output logic            busy1,
  output logic            busy2,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_rd
);

  localparam int C_NRD = 3;

  // Entry 0 of both arrays is held at zero by never being addressed by a
  // qualified write or issue.
  logic [NREG-1:0][XLEN-1:0] r_regs;
  logic [NREG-1:0]           r_pend;

  // Writes and issues to address 0 are dropped right here.
  logic w_wr0;
  logic w_wr1;
  logic w_iss;

  assign w_wr0 = we0   && (wa0    != '0);
  assign w_wr1 = we1   && (wa1    != '0);
  assign w_iss = iss_v && (iss_rd != '0);

  // Statement order sets priorities: port 1 write lands after port 0, and
  // the issue set lands after both clears, so set wins on a same-cycle hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr0) begin
        r_regs[wa0] <= wd0;
        r_pend[wa0] <= 1'b0;
      end
      if (w_wr1) begin
        r_regs[wa1] <= wd1;
        r_pend[wa1] <= 1'b0;
      end
      if (w_iss) begin
        r_pend[iss_rd] <= 1'b1;
      end
    end
  end

  logic [C_NRD-1:0][AW-1:0]   w_ra;
  logic [C_NRD-1:0][XLEN-1:0] w_rd;
  logic [C_NRD-1:0]           w_busy;

  assign w_ra = {ra2, ra1, ra0};

  // Read ports look only at write ports and stored state; the issue port is
  // deliberately absent so a set-wins collision shows busy=0 this cycle.
  // Outputs are forced to zero while reset is asserted so that a write
  // presented during reset cannot leak through the bypass.
  generate
    for (genvar k = 0; k < C_NRD; k++) begin : g_rd
      logic w_hit0;
      logic w_hit1;

      assign w_hit0 = w_wr0 && (wa0 == w_ra[k]);
      assign w_hit1 = w_wr1 && (wa1 == w_ra[k]);

      always_comb begin
        w_rd[k]   = '0;
        w_busy[k] = 1'b0;
        if (rst_n && (w_ra[k] != '0)) begin
          if (w_hit1) begin
            w_rd[k] = wd1;
          end else if (w_hit0) begin
            w_rd[k] = wd0;
          end else begin
            w_rd[k] = r_regs[w_ra[k]];
          end
          w_busy[k] = r_pend[w_ra[k]] && !(w_hit0 || w_hit1);
        end
      end
    end
  endgenerate

  assign rd0   = w_rd[0];
  assign rd1   = w_rd[1];
  assign rd2   = w_rd[2];
  assign busy0 = w_busy[0];
  assign busy1 = w_busy[1];
  assign busy2 = w_busy[2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed, table-driven bench for regfile_mp (default
//               parameters). Each table row is one clock cycle of inputs with
//               the hand-computed outputs expected before the rising edge.
//               Hand-written sequences cover set-wins, asynchronous reset
//               mid-operation, and the first edge after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NVEC = 17;

  logic            clk;
  logic            rst_n;
  logic            we0, we1, iss_v;
  logic [AW-1:0]   wa0, wa1, iss_rd, ra0, ra1, ra2;
  logic [XLEN-1:0] wd0, wd1;
  logic [XLEN-1:0] rd0, rd1, rd2;
  logic            busy0, busy1, busy2;

  int checks;
  int failures;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .ra0    (ra0),
    .ra1    (ra1),
    .ra2    (ra2),
    .rd0    (rd0),
    .rd1    (rd1),
    .rd2    (rd2),
    .busy0  (busy0),
    .busy1  (busy1),
    .busy2  (busy2),
    .iss_v  (iss_v),
    .iss_rd (iss_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            we0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic            iss_v;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] e_rd0;
    logic [XLEN-1:0] e_rd1;
    logic [XLEN-1:0] e_rd2;
    logic [2:0]      e_busy;   // {busy2, busy1, busy0}
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [XLEN-1:0] e0,
                         input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                         input logic [2:0] eb);
    chk({tag, " rd0"}, rd0, e0);
    chk({tag, " rd1"}, rd1, e1);
    chk({tag, " rd2"}, rd2, e2);
    chk({tag, " busy0"}, {31'd0, busy0}, {31'd0, eb[0]});
    chk({tag, " busy1"}, {31'd0, busy1}, {31'd0, eb[1]});
    chk({tag, " busy2"}, {31'd0, busy2}, {31'd0, eb[2]});
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_v = 1'b0; iss_rd = '0;
  endtask

  // Watchdog so the run always reaches a verdict.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //          we0  wa0    wd0           we1  wa1    wd1           iss  rd     ra0    ra1    ra2     e_rd0         e_rd1         e_rd2         busy
    vecs[0]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd5,  5'd31, 5'd0,  32'h0,        32'h0,        32'h0,        3'b000};
    vecs[1]  = '{1'b1,5'd3, 32'hDEADBEEF, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd3,  5'd3,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        3'b000};
    vecs[2]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd3,  5'd0,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        3'b000};
    vecs[3]  = '{1'b1,5'd7, 32'h11,       1'b1,5'd7, 32'h22,       1'b0,5'd0, 5'd7,  5'd3,  5'd0,  32'h22,       32'hDEADBEEF, 32'h0,        3'b000};
    vecs[4]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd7,  5'd7,  5'd0,  32'h22,       32'h22,       32'h0,        3'b000};
    vecs[5]  = '{1'b0,5'd0, 32'h0,        1'b1,5'd0, 32'hFFFFFFFF, 1'b1,5'd0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        3'b000};
    vecs[6]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0,  5'd7,  5'd0,  32'h0,        32'h22,       32'h0,        3'b000};
    vecs[7]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd9, 5'd9,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        3'b000};
    vecs[8]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd9, 5'd9,  5'd9,  5'd0,  32'h0,        32'h0,        32'h0,        3'b011};
    vecs[9]  = '{1'b1,5'd9, 32'h99,       1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd9,  5'd10, 5'd9,  32'h99,       32'h0,        32'h99,       3'b000};
    vecs[10] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd9,  5'd0,  5'd0,  32'h99,       32'h0,        32'h0,        3'b000};
    vecs[11] = '{1'b0,5'd0, 32'h0,        1'b1,5'd9, 32'hAA,       1'b1,5'd9, 5'd9,  5'd0,  5'd0,  32'hAA,       32'h0,        32'h0,        3'b000};
    vecs[12] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd9,  5'd9,  5'd9,  32'hAA,       32'hAA,       32'hAA,       3'b111};
    vecs[13] = '{1'b1,5'd9, 32'hBB,       1'b0,5'd0, 32'h0,        1'b1,5'd4, 5'd4,  5'd0,  5'd9,  32'h0,        32'h0,        32'hBB,       3'b000};
    vecs[14] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd4,  5'd3,  5'd9,  32'h0,        32'hDEADBEEF, 32'hBB,       3'b001};
    vecs[15] = '{1'b1,5'd12,32'h12,       1'b1,5'd13,32'h13,       1'b0,5'd0, 5'd12, 5'd13, 5'd7,  32'h12,       32'h13,       32'h22,       3'b000};
    vecs[16] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd12, 5'd13, 5'd4,  32'h12,       32'h13,       32'h0,        3'b100};

    // Reset held for two cycles with reads of 5, 31, 0.
    idle_inputs();
    rst_n = 1'b0;
    ra0 = 5'd5; ra1 = 5'd31; ra2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive just after an edge, compare at the falling edge.
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      iss_v = vecs[i].iss_v; iss_rd = vecs[i].iss_rd;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_rd0, vecs[i].e_rd1,
              vecs[i].e_rd2, vecs[i].e_busy);
    end

    // Write 0x55 to r4 while re-issuing r4 (pending already set): set wins.
    @(posedge clk);
    #1;
    idle_inputs();
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h55;
    iss_v = 1'b1; iss_rd = 5'd4;
    ra0 = 5'd4; ra1 = 5'd5; ra2 = 5'd0;
    @(negedge clk);
    chk_all("setwin_same", 32'h55, 32'h0, 32'h0, 3'b000);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk_all("setwin_after", 32'h55, 32'h0, 32'h0, 3'b001);

    // Reset pulsed between edges with a write and issue pending.
    #1;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h77;
    iss_v = 1'b1; iss_rd = 5'd5;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 3'b000);
    @(posedge clk);
    #1;
    chk_all("rst_edge", 32'h0, 32'h0, 32'h0, 3'b000);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("rst_discard", 32'h0, 32'h0, 32'h0, 3'b000);

    // First edge after release performs the write and the issue.
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h77;
    iss_v = 1'b1; iss_rd = 5'd5;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    chk_all("post_rst", 32'h77, 32'h0, 32'h0, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
